// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: CPU data-port decoder to DRAM or IO page peripherals; `define MMIO_TIMER_EN adds the 0x020 timer
module mmio_bus_bridge #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_F000,
  parameter int SCAN_DIV = 50000,
  parameter int TIMER_DIV = 100
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdin,
  output logic [31:0] cpu_rd,
  output logic [31:0] dram_adr,
  output logic        dram_we,
  output logic [31:0] dram_wdin,
  input  logic [31:0] dram_rd,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dn_seg
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [127:0] SEG = {8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
                                  8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};
  logic        io_sel, wr;
  logic [11:0] off;
  logic [31:0] disp, timer_rd, io_rdata;
  logic [23:0] sw_s1, sw_s2;
  logic [4:0]  btn_s1, btn_s2;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic        scan_wrap;
  assign io_sel    = cpu_adr[31:12] == IO_BASE[31:12];
  assign off       = cpu_adr[11:0];
  assign wr        = cpu_we & io_sel;
  assign dram_adr  = cpu_adr;
  assign dram_wdin = cpu_wdin;
  assign dram_we   = cpu_we & ~io_sel;
  assign cpu_rd    = io_sel ? io_rdata : dram_rd;
  assign digit     = disp[{idx, 2'b00} +: 4];
  assign scan_wrap = cnt == CW'(SCAN_DIV - 1);
  always_comb
    io_rdata = off == 12'h000 ? disp :
               off == 12'h020 ? timer_rd :
               off == 12'h060 ? {8'b0, led} :
               off == 12'h070 ? {8'b0, sw_s2} :
               off == 12'h078 ? {27'b0, btn_s2} : 32'b0;
  always_ff @(posedge clk)
    if (rst) begin
      disp   <= '0;
      led    <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      cnt    <= '0;
      idx    <= '0;
      dig_en <= 8'hFE;
      dn_seg <= 8'h03;
    end else begin
      if (wr && off == 12'h000) disp <= cpu_wdin;
      if (wr && off == 12'h060) led <= cpu_wdin[23:0];
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      cnt    <= scan_wrap ? '0 : cnt + 1'b1;
      if (scan_wrap) idx <= idx + 1'b1;
      dig_en <= ~(8'b1 << idx);
      dn_seg <= SEG[{digit, 3'b000} +: 8];
    end
`ifdef MMIO_TIMER_EN
  localparam int PW = TIMER_DIV > 1 ? $clog2(TIMER_DIV) : 1;
  logic [31:0]   timer;
  logic [PW-1:0] pre;
  logic          pre_wrap;
  assign pre_wrap = pre == PW'(TIMER_DIV - 1);
  assign timer_rd = timer;
  // A CPU load of the timer restarts the prescaler so the next tick is a full period away
  always_ff @(posedge clk)
    if (rst) begin
      timer <= '0;
      pre   <= '0;
    end else if (wr && off == 12'h020) begin
      timer <= cpu_wdin;
      pre   <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) timer <= timer + 32'd1;
    end
`else
  assign timer_rd = '0;
`endif
endmodule
